// File: rtl/fsm_stim_seq_if.sv
// Control/status bundle of the stimulus sequencer: table write port, run control
// and observation of progress. The bench or a host drives the master side.
interface fsm_stim_seq_if #(
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 5,
  parameter int SIG_W  = 8
) ();
  // Handshake: start is a one-cycle request with no ready; it is honoured only
  // while the sequencer is idle (busy=0, no done) and dropped otherwise. A run
  // ends with done high for exactly one cycle. wr_en is a fire-and-forget write
  // accepted on every cycle it is high.
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [1:0]        wr_sym;
  logic [CNT_W-1:0]  wr_hold;
  logic [ADDR_W:0]   num_steps;
  logic              start;
  logic              loop;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] step_idx;
  logic [SIG_W-1:0]  sig;
  logic [1:0]        state_dbg;

  modport master (
    output wr_en, wr_addr, wr_sym, wr_hold, num_steps, start, loop,
    input  busy, done, step_idx, sig, state_dbg
  );

  modport slave (
    input  wr_en, wr_addr, wr_sym, wr_hold, num_steps, start, loop,
    output busy, done, step_idx, sig, state_dbg
  );
endinterface

// File: rtl/fsm_stim_seq.sv
// Programmable stimulus sequencer: plays {symbol, hold} steps onto state_inputs and
// folds the observed comb_outputs into a rotate-xor signature. Macro STIM_LOOP_EN enables looping.
module fsm_stim_seq #(
  parameter int NSTEP  = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 5,
  parameter int OUT_W  = 4,
  parameter int SIG_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  fsm_stim_seq_if.slave    ctl,
  input  logic [OUT_W-1:0] comb_outputs,
  output logic [0:1]       state_inputs
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [1:0]       tbl_sym  [NSTEP];
  logic [CNT_W-1:0] tbl_hold [NSTEP];

  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] step_idx;
  logic [SIG_W-1:0]  sig;
  logic [ADDR_W:0]   n_lat;
  logic              loop_pulse;

  logic [ADDR_W:0]   idx_inc;
  logic [ADDR_W:0]   n_sat;
  logic [ADDR_W-1:0] nxt_addr;
  logic [SIG_W-1:0]  sig_nxt;
  logic              last_cyc;
  logic              last_step;
  logic              loop_take;

  function automatic logic [CNT_W-1:0] hold_ld(input logic [CNT_W-1:0] h);
    // A zero hold still plays for one cycle.
    return (h == '0) ? '0 : h - CNT_W'(1);
  endfunction

`ifdef STIM_LOOP_EN
  assign loop_take = ctl.loop;
`else
  // loop is observed but never honoured in this build.
  assign loop_take = ctl.loop & 1'b0;
`endif

  assign idx_inc   = {1'b0, step_idx} + (ADDR_W+1)'(1);
  assign last_step = (idx_inc >= n_lat);
  assign last_cyc  = (state == S_RUN) && (cnt == '0);
  assign nxt_addr  = last_step ? '0 : idx_inc[ADDR_W-1:0];
  assign n_sat     = (ctl.num_steps > (ADDR_W+1)'(NSTEP)) ? (ADDR_W+1)'(NSTEP)
                                                          : ctl.num_steps;
  assign sig_nxt   = {sig[SIG_W-2:0], sig[SIG_W-1]} ^ SIG_W'(comb_outputs);

  // Table is deliberately not reset so a program survives a sequencer reset.
  always_ff @(posedge clk) begin
    if (ctl.wr_en) begin
      tbl_sym[ctl.wr_addr]  <= ctl.wr_sym;
      tbl_hold[ctl.wr_addr] <= ctl.wr_hold;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (ctl.start) state_nxt = (ctl.num_steps != '0) ? S_RUN : S_DONE;
      S_RUN:  if (last_cyc && last_step && !loop_take) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ctl.busy      = (state == S_RUN);
    ctl.done      = (state == S_DONE) || loop_pulse;
    ctl.state_dbg = state;
    ctl.step_idx  = step_idx;
    ctl.sig       = sig;
  end

  // Symbol and hold are latched on step entry, so writes to the playing entry
  // only show up the next time that entry is replayed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_inputs <= 2'b00;
      step_idx     <= '0;
      sig          <= '0;
      cnt          <= '0;
      n_lat        <= '0;
      loop_pulse   <= 1'b0;
    end else begin
      loop_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ctl.start && (ctl.num_steps != '0)) begin
            n_lat        <= n_sat;
            step_idx     <= '0;
            sig          <= '0;
            state_inputs <= tbl_sym[0];
            cnt          <= hold_ld(tbl_hold[0]);
          end
        end
        S_RUN: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            sig <= sig_nxt;
            if (!last_step || loop_take) begin
              step_idx     <= nxt_addr;
              state_inputs <= tbl_sym[nxt_addr];
              cnt          <= hold_ld(tbl_hold[nxt_addr]);
              loop_pulse   <= last_step;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
